// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-game datapath.
package game_pkg;

    localparam int SYM_W    = 2;
    localparam int NUM_KEYS = 4;

    // Fibonacci feedback taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PLAY,
        ST_USER
    } state_t;

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [SYM_W-1:0] sym);
        logic [NUM_KEYS-1:0] v;
        v      = '0;
        v[sym] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/game_datapath_if.sv
// Command/status bundle between the game controller, board I/O and the datapath.
interface game_datapath_if #(
    parameter int SEQ_LEN = 16
);
    import game_pkg::*;

    localparam int RL_W = $clog2(SEQ_LEN) + 1;

    logic             R1, R2, E1, E2, E3, E4, SEL;
    logic             key_valid;
    logic [SYM_W-1:0] key_code;

    logic                end_FPGA, end_User, end_time, win, match;
    logic [NUM_KEYS-1:0] led;
    logic [RL_W-1:0]     round_len;

    modport master (
        output R1, R2, E1, E2, E3, E4, SEL, key_valid, key_code,
        input  end_FPGA, end_User, end_time, win, match, led, round_len
    );

    modport slave (
        input  R1, R2, E1, E2, E3, E4, SEL, key_valid, key_code,
        output end_FPGA, end_User, end_time, win, match, led, round_len
    );

endinterface

// File: rtl/tick_counter.sv
// Enabled cycle counter with synchronous clear; pulses o_tc on the last tick and wraps.
module tick_counter #(
    parameter int TICKS = 4
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);
    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en & (r_cnt == LAST);

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/game_datapath.sv
// Memory-game datapath: LFSR sequence fill, LED playback, key checking and idle timeout.
// state | meaning
// IDLE  | waiting for a command
// FILL  | writing SEQ_LEN LFSR symbols into the sequence memory
// PLAY  | showing round_len symbols on the LEDs
// USER  | checking key entries against the sequence
module game_datapath
    import game_pkg::*;
#(
    parameter int          SEQ_LEN       = 16,
    parameter int          STEP_TICKS    = 25000000,
    parameter int          TIMEOUT_TICKS = 250000000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic         CLOCK,
    input logic         reset,
    game_datapath_if.slave bus
);
    localparam int IDX_W  = $clog2(SEQ_LEN);
    localparam int RL_W   = IDX_W + 1;
    localparam int SHOW_W = $clog2(STEP_TICKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [RL_W-1:0]  RL_MAX   = RL_W'(SEQ_LEN);

    state_t              r_state, w_next;
    logic [15:0]         r_lfsr;
    logic [SYM_W-1:0]    r_seq [SEQ_LEN];
    logic [IDX_W-1:0]    r_wr_idx, r_play_idx, r_usr_idx;
    logic [RL_W-1:0]     r_round_len;
    logic                r_end_fpga, r_end_user, r_end_time, r_win, r_match;
    logic                r_gap, r_e1_d;
    logic [SYM_W-1:0]    r_last_key;
    logic [SHOW_W-1:0]   r_show_cnt;
    logic [NUM_KEYS-1:0] w_play_led, w_user_led;

    logic w_do_r2, w_clr_round, w_do_e1, w_do_e4, w_do_e2, w_do_e3, w_e1_rise;
    logic w_fill_wr, w_play_run, w_user_run, w_key_acc, w_key_ok;
    logic w_step_tc, w_idle_tc;

    // Only the highest-priority asserted command acts: R2 > R1 > E1 > E4 > E2 > E3
    assign w_do_r2     = bus.R2;
    assign w_clr_round = bus.R2 | bus.R1;
    assign w_do_e1     = bus.E1 & ~w_clr_round;
    assign w_do_e4     = bus.E4 & ~w_clr_round & ~bus.E1;
    assign w_do_e2     = bus.E2 & ~w_clr_round & ~bus.E1 & ~bus.E4;
    assign w_do_e3     = bus.E3 & ~w_clr_round & ~bus.E1 & ~bus.E4 & ~bus.E2;
    assign w_e1_rise   = bus.E1 & ~r_e1_d;

    assign w_fill_wr  = (r_state == ST_FILL) & ~w_clr_round;
    assign w_play_run = (r_state == ST_PLAY) & w_do_e2 & ~r_end_fpga;
    assign w_user_run = (r_state == ST_USER) & w_do_e3 & ~r_end_user & ~r_end_time;
    assign w_key_acc  = w_user_run & bus.key_valid;
    assign w_key_ok   = (bus.key_code == r_seq[r_usr_idx]);

    tick_counter #(.TICKS(STEP_TICKS)) u_step_timer (
        .CLOCK (CLOCK),
        .reset (reset),
        .i_en  (w_play_run & ~r_gap),
        .i_clr (w_clr_round),
        .o_tc  (w_step_tc)
    );

    tick_counter #(.TICKS(TIMEOUT_TICKS)) u_idle_timer (
        .CLOCK (CLOCK),
        .reset (reset),
        .i_en  (w_user_run),
        .i_clr (w_clr_round | w_key_acc),
        .o_tc  (w_idle_tc)
    );

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_clr_round) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_do_e1 & w_e1_rise) w_next = ST_FILL;
                    else if (w_do_e2)        w_next = ST_PLAY;
                    else if (w_do_e3)        w_next = ST_USER;
                end
                ST_FILL: if (r_wr_idx == LAST_IDX) w_next = ST_IDLE;
                ST_PLAY: if (~bus.E2 & r_end_fpga) w_next = ST_IDLE;
                ST_USER: if (~bus.E3 & (r_end_user | r_end_time)) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_play_led = '0;
        w_user_led = '0;
        if ((r_state == ST_PLAY) & ~r_end_fpga & ~r_gap)
            w_play_led = onehot(r_seq[r_play_idx]);
        if (r_show_cnt != '0)
            w_user_led = onehot(r_last_key);
    end

    assign bus.led       = bus.SEL ? w_user_led : w_play_led;
    assign bus.end_FPGA  = r_end_fpga;
    assign bus.end_User  = r_end_user;
    assign bus.end_time  = r_end_time;
    assign bus.win       = r_win;
    assign bus.match     = r_match;
    assign bus.round_len = r_round_len;

    // Sequence memory has no reset; contents are only meaningful after a fill
    always_ff @(posedge CLOCK) begin
        if (w_fill_wr)
            r_seq[r_wr_idx] <= r_lfsr[SYM_W-1:0];
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_lfsr      <= LFSR_SEED;
            r_e1_d      <= 1'b0;
            r_wr_idx    <= '0;
            r_play_idx  <= '0;
            r_usr_idx   <= '0;
            r_round_len <= RL_W'(1);
            r_end_fpga  <= 1'b0;
            r_end_user  <= 1'b0;
            r_end_time  <= 1'b0;
            r_win       <= 1'b0;
            r_match     <= 1'b1;
            r_gap       <= 1'b0;
            r_last_key  <= '0;
            r_show_cnt  <= '0;
        end else begin
            r_e1_d <= bus.E1;
            r_lfsr <= w_do_r2 ? LFSR_SEED : {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
            if (w_clr_round) begin
                r_wr_idx   <= '0;
                r_play_idx <= '0;
                r_usr_idx  <= '0;
                r_end_fpga <= 1'b0;
                r_end_user <= 1'b0;
                r_end_time <= 1'b0;
                r_match    <= 1'b1;
                r_gap      <= 1'b0;
                r_show_cnt <= '0;
                if (w_do_r2) begin
                    r_round_len <= RL_W'(1);
                    r_win       <= 1'b0;
                end
            end else begin
                if (w_fill_wr)
                    r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_W'(1);
                if (w_do_e4 && (r_round_len < RL_MAX)) begin
                    r_round_len <= r_round_len + RL_W'(1);
                    if (r_round_len == RL_MAX - RL_W'(1))
                        r_win <= 1'b1;
                end
                // Each symbol is followed by one dark cycle so repeats stay visible
                if (w_play_run) begin
                    if (r_gap) begin
                        r_gap      <= 1'b0;
                        r_play_idx <= r_play_idx + IDX_W'(1);
                        if (RL_W'(r_play_idx) + RL_W'(1) == r_round_len)
                            r_end_fpga <= 1'b1;
                    end else if (w_step_tc) begin
                        r_gap <= 1'b1;
                    end
                end
                if (w_key_acc) begin
                    r_last_key <= bus.key_code;
                    r_show_cnt <= SHOW_W'(STEP_TICKS);
                    if (w_key_ok) begin
                        r_usr_idx <= r_usr_idx + IDX_W'(1);
                        if (RL_W'(r_usr_idx) + RL_W'(1) == r_round_len)
                            r_end_user <= 1'b1;
                    end else begin
                        r_match    <= 1'b0;
                        r_end_user <= 1'b1;
                    end
                end else if (r_show_cnt != '0) begin
                    r_show_cnt <= r_show_cnt - SHOW_W'(1);
                end
                if (w_idle_tc & ~w_key_acc)
                    r_end_time <= 1'b1;
            end
        end
    end

endmodule
